config_chain_ctrl: RTL

CONFIG_CHAIN_CTRL -- requirements
Module: config_chain_ctrl

---
 rtl/config_chain_pkg.sv | 15 +
 rtl/ccff_word_shifter.sv | 64 ++++++
 rtl/config_chain_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/config_chain_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and
// default geometry of the chain and of one bitstream word.
package config_chain_pkg;

  localparam int DEF_CHAIN_LEN = 16;
  localparam int DEF_WORD_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage : config_chain_pkg

// File: rtl/ccff_word_shifter.sv
// Word buffer plus the two down-counters that pace serialisation: bits left in
// the whole chain and bits left in the current word.
module ccff_word_shifter #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              head_o,
  output logic              word_last_o,
  output logic              chain_last_o
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic [BIT_W-1:0]  bits_q, bits_d;

  always_comb begin
    buf_d    = buf_q;
    remain_d = remain_q;
    bits_d   = bits_q;
    if (init_i) begin
      remain_d = CNT_W'(CHAIN_LEN);
    end
    if (load_i) begin
      buf_d  = word_i;
      bits_d = BIT_W'(WORD_W);
    end
    if (shift_i) begin
      buf_d = buf_q >> 1;
      // Both counters saturate at zero so neither can wrap.
      if (remain_q != '0) remain_d = remain_q - CNT_W'(1);
      if (bits_q != '0)   bits_d   = bits_q - BIT_W'(1);
    end
  end

  // NOTE: the buffer is a handful of flops, not a RAM, so it takes the async
  // reset along with the counters and powers up to a known all-zero value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q    <= '0;
      remain_q <= '0;
      bits_q   <= '0;
    end else begin
      buf_q    <= buf_d;
      remain_q <= remain_d;
      bits_q   <= bits_d;
    end
  end

  assign head_o       = buf_q[0];
  // A word ends either when its own bits run out or when the chain is full;
  // upper bits of a final partial word are simply never shifted.
  assign word_last_o  = (bits_q == BIT_W'(1));
  assign chain_last_o = (remain_q == CNT_W'(1));

endmodule : ccff_word_shifter

// File: rtl/config_chain_ctrl.sv
// Serial configuration-chain loader: pulls bitstream words over a valid/ready
// handshake and shifts them LSB-first into the chain, reporting load parity.
module config_chain_ctrl
  import config_chain_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  output logic              busy,
  output logic              done,
  output logic              parity
);

  state_e state_q, state_d;
  logic   run_par_q, run_par_d;
  logic   parity_q, parity_d;
  logic   head, word_last, chain_last;
  logic   init, accept, shift_en;

  assign init     = (state_q == IDLE) && start && !abort;
  assign accept   = (state_q == LOAD) && word_valid && !abort;
  assign shift_en = (state_q == SHIFT) && !abort;

  ccff_word_shifter #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W)
  ) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_i      (init),
    .load_i      (accept),
    .shift_i     (shift_en),
    .word_i      (word_data),
    .head_o      (head),
    .word_last_o (word_last),
    .chain_last_o(chain_last)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    run_par_d = run_par_q;
    parity_d  = parity_q;
    unique case (state_q)
      IDLE: begin
        if (init) begin
          state_d   = LOAD;
          run_par_d = 1'b0;
        end
      end
      LOAD: begin
        if (abort)           state_d = IDLE;
        else if (word_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          run_par_d = run_par_q ^ head;
          if (chain_last)     state_d = DONE;
          else if (word_last) state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!abort) parity_d = run_par_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      run_par_q <= 1'b0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_par_q <= run_par_d;
      parity_q  <= parity_d;
    end
  end

  assign word_ready = (state_q == LOAD);
  assign ccff_en    = (state_q == SHIFT);
  assign ccff_head  = ccff_en & head;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign parity     = parity_q;

endmodule : config_chain_ctrl
